// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution, redirect/flush control and 2-bit BHT
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   EX instruction handshake; in_ready depends on FSM state only
//   in_kind             00 none, 01 conditional branch, 10 JAL, 11 JALR
//   in_pc/in_imm/in_rs1 instruction PC, sign-extended immediate, JALR base
//   in_cond             comparator result (bit 0 only)
//   in_pred_taken       direction fetch predicted for this instruction
//   pred_pc/pred_taken  fetch-side BHT lookup (combinational, no bypass)
//   redirect_valid/pc   one-cycle redirect to the corrected next PC
//   flush               kill younger IF/ID instructions
//   link_valid/data     one-cycle rd write of pc+4 for JAL/JALR
//   exc_valid/exc_pc    misaligned-target trap pending, held until trap_ack
//   trap_ack            trap handler has taken the exception
module branch_resolve #(
  parameter int REG_SIZE     = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_kind,
  input  logic [REG_SIZE-1:0] in_pc,
  input  logic [REG_SIZE-1:0] in_imm,
  input  logic [REG_SIZE-1:0] in_rs1,
  input  logic [REG_SIZE-1:0] in_cond,
  input  logic                in_pred_taken,
  input  logic [REG_SIZE-1:0] pred_pc,
  output logic                pred_taken,
  output logic                redirect_valid,
  output logic [REG_SIZE-1:0] redirect_pc,
  output logic                flush,
  output logic                link_valid,
  output logic [REG_SIZE-1:0] link_data,
  output logic                exc_valid,
  output logic [REG_SIZE-1:0] exc_pc,
  input  logic                trap_ack
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FLUSH = 2'b01,
    S_TRAP  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                accept;
  logic                is_jump;
  logic                taken;
  logic                misaligned;
  logic                mispredict;
  logic [REG_SIZE-1:0] jalr_sum;
  logic [REG_SIZE-1:0] target;
  logic [REG_SIZE-1:0] link_pc;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] rd_idx;

  // Only bit 0 of the comparator result, the index bits of pred_pc and the
  // upper bits of the JALR sum carry information.
  logic unused_bits;
  assign unused_bits = ^{in_cond[REG_SIZE-1:1], pred_pc, jalr_sum[0]};

  // Readiness is a pure state decode so fetch/decode never sees a
  // combinational path from in_valid back to in_ready.
  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  // ------------------------------------------------------------------
  // Outcome and target
  // ------------------------------------------------------------------
  assign jalr_sum = in_rs1 + in_imm;
  assign link_pc  = in_pc + REG_SIZE'(4);
  assign is_jump  = (in_kind == KIND_JAL) || (in_kind == KIND_JALR);

  always_comb begin
    taken  = 1'b0;
    target = in_pc + in_imm;
    case (in_kind)
      KIND_BR:   taken = in_cond[0];
      KIND_JAL:  taken = 1'b1;
      KIND_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[REG_SIZE-1:1], 1'b0};
      end
      default:   taken = 1'b0;
    endcase
  end

  // A not-taken branch never faults, whatever its encoded target.
  assign misaligned = taken && (target[1:0] != 2'b00);

  // JALR targets are not predicted by fetch, so JALR always redirects.
  assign mispredict = (in_kind != KIND_NONE) &&
                      ((taken != in_pred_taken) || (in_kind == KIND_JALR));

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    exc_valid      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && (in_kind != KIND_NONE)) begin
          // A faulting target suppresses the redirect; the trap wins.
          if (misaligned) begin
            state_d = S_TRAP;
          end else if (mispredict) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        flush          = 1'b1;
        redirect_valid = (cnt_q == '0);
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TRAP: begin
        exc_valid = 1'b1;
        if (trap_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registered data outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= '0;
      link_valid  <= 1'b0;
      link_data   <= '0;
      exc_pc      <= '0;
    end else begin
      link_valid <= 1'b0;
      if (accept) begin
        if (is_jump && !misaligned) begin
          link_valid <= 1'b1;
          link_data  <= link_pc;
        end
        if (mispredict && !misaligned) begin
          redirect_pc <= taken ? target : link_pc;
        end
        if (misaligned) begin
          exc_pc <= in_pc;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Branch history table
  // ------------------------------------------------------------------
  assign upd_idx    = in_pc[IDX_W+1:2];
  assign rd_idx     = pred_pc[IDX_W+1:2];
  // Read sees the pre-update counter; fetch tolerates the one-cycle lag.
  assign pred_taken = bht_q[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (accept && (in_kind == KIND_BR)) begin
      // Misaligned taken branches still train the predictor.
      if (in_cond[0]) begin
        if (bht_q[upd_idx] != 2'b11) begin
          bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
        end
      end else begin
        if (bht_q[upd_idx] != 2'b00) begin
          bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
module tb_branch_resolve;

  localparam int FLUSH_N = 2;
  localparam int NENT    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = 2'b00;
  logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_cond = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        link_valid;
  logic [31:0] link_data;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        trap_ack = 1'b0;

  branch_resolve #(.REG_SIZE(32), .BHT_ENTRIES(NENT), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_cond(in_cond),
    .in_pred_taken(in_pred_taken), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .link_valid(link_valid), .link_data(link_data),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    logic [31:0] rpc;
    bit          l;
    logic [31:0] ld;
    bit          e;
    logic [31:0] epc;
  } ev_t;

  ev_t exp_q[$];
  int  bht_m[NENT];
  int  pending_stall = 0;
  int  n_vec = 0;
  int  n_err = 0;
  bit  exc_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pred(input logic [31:0] pc);
    return bht_m[(pc >> 2) % NENT] >= 2;
  endfunction

  // Monitor: every redirect/link pulse or trap entry consumes one expectation.
  initial begin
    ev_t e;
    bit  exc_rise;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exc_prev = 1'b0;
      end else begin
        exc_rise = exc_valid && !exc_prev;
        exc_prev = exc_valid;
        if (redirect_valid || link_valid || exc_rise) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {29'd0, redirect_valid, link_valid, exc_rise}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.r});
            if (e.r) chk("redirect_pc", redirect_pc, e.rpc);
            if (e.r) chk("flush_with_redirect", {31'd0, flush}, 32'd1);
            chk("link_valid", {31'd0, link_valid}, {31'd0, e.l});
            if (e.l) chk("link_data", link_data, e.ld);
            chk("exc_valid_rise", {31'd0, exc_rise}, {31'd0, e.e});
            if (e.e) chk("exc_pc", exc_pc, e.epc);
          end
        end
      end
    end
  end

  task automatic drain_stall();
    int w = 0;
    while (pending_stall > 0) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_flush", {31'd0, flush}, 32'd1);
      pending_stall--;
      @(negedge clk);
    end
    chk("in_ready_after_stall", {31'd0, in_ready}, 32'd1);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic idle_cycle();
    if (pending_stall > 0) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      pending_stall--;
    end
    @(negedge clk);
  endtask

  // Starts and ends at a falling edge; consecutive calls give back-to-back issue.
  task automatic send(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic [31:0] cond, input bit pred,
                      input logic [31:0] ppc, input int hold, input bit rand_ack);
    bit          taken, mis, mp;
    logic [31:0] target;
    ev_t         ev;
    drain_stall();
    in_valid      = 1'b1;
    in_kind       = kind;
    in_pc         = pc;
    in_imm        = imm;
    in_rs1        = rs1;
    in_cond       = cond;
    in_pred_taken = pred;
    pred_pc       = ppc;
    trap_ack      = rand_ack ? ($urandom_range(0, 3) == 0) : 1'b0;
    #1;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, model_pred(ppc)});
    @(posedge clk);
    taken  = (kind == 2'b01) ? cond[0] : (kind != 2'b00);
    target = (kind == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    mis    = taken && (target % 4 != 0);
    mp     = (kind != 2'b00) && ((taken != pred) || (kind == 2'b11));
    ev.e   = mis;
    ev.epc = pc;
    ev.l   = (kind >= 2'b10) && !mis;
    ev.ld  = pc + 4;
    ev.r   = mp && !mis;
    ev.rpc = taken ? target : pc + 4;
    if (ev.e || ev.l || ev.r) exp_q.push_back(ev);
    pending_stall = ev.r ? FLUSH_N : 0;
    if (kind == 2'b01) begin
      if (cond[0]) bht_m[(pc >> 2) % NENT] = (bht_m[(pc >> 2) % NENT] == 3) ? 3 : bht_m[(pc >> 2) % NENT] + 1;
      else         bht_m[(pc >> 2) % NENT] = (bht_m[(pc >> 2) % NENT] == 0) ? 0 : bht_m[(pc >> 2) % NENT] - 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    trap_ack = 1'b0;
    if (mis) begin
      for (int i = 0; i < hold; i++) begin
        chk("trap_exc_held", {31'd0, exc_valid}, 32'd1);
        chk("trap_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
      end
      trap_ack = 1'b1;
      @(posedge clk);
      #1 trap_ack = 1'b0;
      @(negedge clk);
      chk("trap_cleared", {31'd0, exc_valid}, 32'd0);
      chk("trap_in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    foreach (bht_m[i]) bht_m[i] = 1;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("reset_exc", {31'd0, exc_valid}, 32'd0);
    chk("reset_link", {31'd0, link_valid}, 32'd0);

    // Directed cases.
    send(2'b01, 32'h100, 32'h40, 0, 0, 1'b0, 32'h100, 0, 1'b0);
    send(2'b01, 32'h100, 32'h40, 0, 1, 1'b0, 32'h100, 0, 1'b0);
    send(2'b11, 32'h80, 32'h3, 32'h2001, 0, 1'b1, 32'h80, 0, 1'b0);
    send(2'b10, 32'h200, 32'h6, 0, 0, 1'b1, 32'h200, 5, 1'b0);
    for (int i = 0; i < 4; i++) send(2'b01, 32'h10, 32'h40, 0, 1, model_pred(32'h10), 32'h10, 0, 1'b0);
    drain_stall();
    pred_pc = 32'h10;
    #1 chk("bht_sat_high", {31'd0, pred_taken}, 32'd1);
    for (int i = 0; i < 3; i++) send(2'b01, 32'h10, 32'h40, 0, 0, model_pred(32'h10), 32'h10, 0, 1'b0);
    drain_stall();
    pred_pc = 32'h10;
    #1 chk("bht_sat_low", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  k;
      logic [31:0] pc, imm, rs1;
      int          sel;
      sel = $urandom_range(0, 7);
      k   = (sel == 0) ? 2'b00 : (sel <= 4) ? 2'b01 : (sel == 5) ? 2'b10 : 2'b11;
      pc  = $urandom_range(0, 255) << 2;
      imm = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'h2;
      rs1 = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rs1 = rs1 | ($urandom & 3);
      send(k, pc, imm, rs1, $urandom,
           ($urandom_range(0, 3) == 0) ? 1'($urandom) : model_pred(pc),
           ($urandom_range(0, 1) == 0) ? pc : ($urandom_range(0, 255) << 2),
           $urandom_range(0, 4), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset during the second flush cycle.
    for (int i = 0; i < 3; i++) send(2'b01, 32'h20, 32'h8, 0, 1, model_pred(32'h20), 32'h20, 0, 1'b0);
    drain_stall();
    pred_pc = 32'h20;
    #1 chk("bht_trained", {31'd0, pred_taken}, 32'd1);
    @(negedge clk);
    send(2'b01, 32'h100, 32'h40, 0, 0, 1'b1, 32'h20, 0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush_drop", {31'd0, flush}, 32'd0);
    chk("rst_redirect_drop", {31'd0, redirect_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    foreach (bht_m[i]) bht_m[i] = 1;
    pending_stall = 0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_flush", {31'd0, flush}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pred_pc = $urandom;
      if (i == 0) pred_pc = 32'h20;
      #1 chk("post_rst_pred", {31'd0, pred_taken}, 32'd0);
    end
    send(2'b01, 32'h20, 32'h8, 0, 0, 1'b0, 32'h20, 0, 1'b0);
    drain_stall();
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
